// File: rtl/pk_pkg.sv
// rtl/pk_pkg.sv - shared constants, state encoding and record field helpers for the credential store
package pk_pkg;
   localparam int REC_W   = 256;
   localparam int ADDR_W  = 4;
   localparam int SLOTS   = 16;
   localparam int ACC_HI  = 255;
   localparam int ACC_LO  = 128;
   localparam int PASS_HI = 127;
   localparam int PASS_LO = 0;

   typedef enum logic {ST_IDLE, ST_ERASE} state_e;

   function automatic logic [ACC_HI-ACC_LO:0] acc_field(input logic [REC_W-1:0] rec);
      return rec[ACC_HI:ACC_LO];
   endfunction

   function automatic logic [PASS_HI-PASS_LO:0] pass_field(input logic [REC_W-1:0] rec);
      return rec[PASS_HI:PASS_LO];
   endfunction
endpackage

// File: rtl/flash_store_if.sv
// rtl/flash_store_if.sv - flash port between the password-keeper core (master) and the store (slave)
interface flash_store_if;
   import pk_pkg::*;

   logic [ADDR_W-1:0] add_flash;
   logic [REC_W-1:0]  write_data_flash;
   logic              flash_write;
   logic              erase;
   logic [REC_W-1:0]  data_flash;
   logic [ADDR_W-1:0] max_address;
   logic              full;
   logic              busy;
   logic              wr_ack;
   logic              wr_err;

   modport master (
      output add_flash, write_data_flash, flash_write, erase,
      input  data_flash, max_address, full, busy, wr_ack, wr_err
   );

   modport slave (
      input  add_flash, write_data_flash, flash_write, erase,
      output data_flash, max_address, full, busy, wr_ack, wr_err
   );
endinterface

// File: rtl/flash_store_mem.sv
// rtl/flash_store_mem.sv - single-port write-first record array with registered read
// Deliberately unreset: contents model flash retention across reset.
module flash_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 256,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
         rdata_q       <= wdata_i;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/flash_store.sv
// rtl/flash_store.sv - 16-record credential store: append/overwrite control, occupancy and sequenced erase
module flash_store
   import pk_pkg::*;
#(
   parameter int DEPTH = SLOTS,
   parameter int WIDTH = REC_W
) (
   input  logic         clk,
   input  logic         rst,
   flash_store_if.slave fif
);
   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   count_q, count_d;
   logic              wr_ack_q, wr_err_q;
   logic              rd_zero_q;

   logic              in_idle, erase_last, wr_ok, wr_do, wr_append;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata, mem_rdata;

   assign in_idle    = (state_q == ST_IDLE);
   assign erase_last = (ptr_q == ADDR_W'(DEPTH - 1));
   // When full the append slot (16) is unreachable, so this admits overwrites only.
   assign wr_ok      = ({1'b0, fif.add_flash} <= count_q);
   assign wr_do      = in_idle & ~fif.erase & fif.flash_write & wr_ok;
   assign wr_append  = wr_do & ({1'b0, fif.add_flash} == count_q);

   assign mem_we    = ~in_idle | wr_do;
   assign mem_addr  = in_idle ? fif.add_flash : ptr_q;
   assign mem_wdata = in_idle ? fif.write_data_flash : '0;

   flash_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(ADDR_W)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      count_d = count_q;
      if (!in_idle && erase_last) begin
         count_d = '0;
      end else if (wr_append) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         count_q   <= '0;
         wr_ack_q  <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_zero_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         wr_ack_q <= wr_do;
         wr_err_q <= fif.flash_write & ~wr_do;
         case (state_q)
            ST_IDLE: begin
               rd_zero_q <= fif.erase;
               if (fif.erase) begin
                  state_q <= ST_ERASE;
                  ptr_q   <= '0;
               end
            end
            ST_ERASE: begin
               ptr_q <= ptr_q + 1'b1;
               if (erase_last) begin
                  state_q   <= ST_IDLE;
                  rd_zero_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // The array read register has no reset; this mask gives zero read data out of reset and at erase start.
   assign fif.data_flash  = rd_zero_q ? '0 : mem_rdata;
   assign fif.max_address = count_q[ADDR_W] ? '1 : count_q[ADDR_W-1:0];
   assign fif.full        = count_q[ADDR_W];
   assign fif.busy        = ~in_idle;
   assign fif.wr_ack      = wr_ack_q;
   assign fif.wr_err      = wr_err_q;
endmodule

// File: doc/flash_store.md
# flash_store

Non-volatile credential store that answers the flash interface of the password-keeper core. It holds up to 16 encrypted records of 256 bits each: account ciphertext in bits [255:128], password ciphertext in bits [127:0]. It serves registered reads on `add_flash` and accepts record writes on `flash_write`. It also reports the occupancy bound the core's FSM scans against. A sequenced erase clears the store.

## Interface
- `DEPTH`, default 16: number of record slots. Fixed at 16 by the 4-bit address.
- `WIDTH`, default 256: record width in bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `add_flash` in 4: record address for both read and write.
- `write_data_flash` in 256: record to store.
- `flash_write` in 1: write strobe, one record per high cycle.
- `erase` in 1: single-cycle request to clear the whole store.
- `data_flash` out 256: registered read data for `add_flash`.
- `max_address` out 4: next free slot; saturates at 15 when full.
- `full` out 1: all 16 slots valid.
- `busy` out 1: erase in progress.
- `wr_ack` out 1: one-cycle pulse, write accepted.
- `wr_err` out 1: one-cycle pulse, write rejected.

## Operation
- A 5-bit `count` holds the number of valid records (0..16). `max_address` = `count[3:0]` when `count` < 16, else 4'hF. `full` = (`count` == 16).
- Write acceptance rules, evaluated in IDLE with `flash_write` = 1:
  - `add_flash` < `count`: overwrite the record (password update). `count` is unchanged.
  - `add_flash` == `count` and not full: append the record and increment `count`.
  - `add_flash` > `count`: reject. Nothing is stored and `wr_err` pulses.
  - Full: overwrites of any slot are accepted. There is no append.
- Read: `data_flash` <= mem[`add_flash`] on every IDLE cycle, regardless of valid state. Reads of unwritten slots return stale contents; the core bounds its scan with `max_address`.
- Read-during-write to the same address returns the new data (write-first).
- State machine, 2 states:
  - IDLE: accepts reads and writes. `erase` = 1 moves to ERASE, loads the erase pointer with 0 and sets `busy`.
  - ERASE: writes 0 to mem[ptr] and increments ptr, one slot per cycle. `data_flash` holds 0.
    - After the write to slot 15, return to IDLE, clear `count` and drop `busy`.
    - `flash_write` during ERASE is dropped and `wr_err` pulses.
    - `erase` during ERASE is ignored.
- Simultaneous `erase` and `flash_write` in IDLE: erase wins. The write is dropped and `wr_err` pulses.

## Timing
- Reset values:
  - `data_flash` = 0, `max_address` = 0, `full` = 0, `busy` = 0, `wr_ack` = 0, `wr_err` = 0.
  - `count` = 0, state = IDLE, ptr = 0.
  - Memory contents are not reset. This models flash retention; contents are invalid until rewritten because `count` = 0.
- Read latency: 1 cycle from `add_flash` to `data_flash`.
- Write: mem, `count` and `max_address` update at the strobe edge. `wr_ack`/`wr_err` are high in the cycle after the strobe.
- Erase: `busy` is high for exactly 16 cycles, starting the cycle after `erase`. `max_address` reads 0 in the cycle `busy` falls.
- Reset asserted mid-erase: the erase aborts immediately and `count` = 0. Partially erased contents are irrelevant.

## Structure
- Shared package `pk_pkg` holds:
  - `REC_W` = 256, `ADDR_W` = 4, `SLOTS` = 16.
  - the state enum {ST_IDLE, ST_ERASE}.
  - field slices `ACC_HI`/`ACC_LO` = 255/128 and `PASS_HI`/`PASS_LO` = 127/0.
- One natural sub-module: `flash_mem`, a 16x256 single-port write-first array with a registered read and no reset. Control, `count` and the FSM stay in `flash_store`.

## Test plan
- Reset, then three appends at addresses 0, 1, 2 with data A, B, C -> three `wr_ack` pulses, `max_address` 3, reads return A/B/C one cycle after each address.
- Write to address 5 while `count` = 3 -> `wr_err` pulse, `max_address` stays 3, read of slot 5 is not data D.
- Overwrite address 1 with D, with `add_flash` held at 1 -> `data_flash` = D the next cycle, `count` unchanged.
- Fill 16 slots -> `full` = 1 and `max_address` = 15. A write to 15 is acked; a write to any address while full never appends.
- `erase` together with `flash_write` -> `wr_err`, `busy` high for 16 cycles, `data_flash` = 0, then `max_address` 0 and `full` 0. Reading slot 0 afterwards returns 0.
- Assert `rst` low at erase cycle 7 -> `busy` drops asynchronously, `count` = 0. After release, an append at 0 is acked.
